// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp patterns and default phase durations (in 0.1 s slots)
// for the two-way intersection sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_AR1  = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6
  } state_t;

  // Lamp patterns are {R,Y,G}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int T_GREEN_DEF     = 70;
  localparam int T_YELLOW_DEF    = 30;
  localparam int T_ALLRED_DEF    = 10;
  localparam int T_MIN_GREEN_DEF = 20;
  localparam int T_WALK_DEF      = 50;

  // Index of the final slot of a phase; a zero duration behaves as one slot.
  function automatic logic [6:0] last_slot(logic [6:0] dur);
    return (dur == 7'd0) ? 7'd0 : dur - 7'd1;
  endfunction

endpackage

// File: rtl/traffic_seq_if.sv
// Board-side signal bundle of the traffic sequencer: run/pedestrian inputs,
// lamp drives and display status.
interface traffic_seq_if;
  logic       enable;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;
  logic [6:0] slot_left;

  modport master (
    output enable, ped_req,
    input  ns_light, ew_light, walk, phase, slot_left
  );

  modport slave (
    input  enable, ped_req,
    output ns_light, ew_light, walk, phase, slot_left
  );
endinterface

// File: rtl/slot_timer.sv
// Phase timer: prescaler producing one tick per 0.1 s slot plus a 7-bit slot counter
// that reports the tick on which the last slot of the current duration ends.
module slot_timer
  import traffic_pkg::*;
#(
  parameter int SLOT_CYCLES = 12_500_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       run,
  input  logic [6:0] duration,
  output logic       tick,
  output logic       done,
  output logic [6:0] slot_cnt
);

  localparam int             PRE_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SLOT_CYCLES - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       cnt_q, cnt_d;

  assign tick     = run && (pre_q == PRE_LAST);
  assign done     = tick && (cnt_q == last_slot(duration));
  assign slot_cnt = cnt_q;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = done ? 7'd0 : cnt_q + 7'd1;
    end else if (run) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_seq.sv
// NS/EW intersection phase sequencer: FSM, registered lamp decode and display status.
// Define PED_XING_EN to add the pedestrian request latch and the inserted walk phase.
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ    = 125_000_000,
  parameter int T_GREEN     = T_GREEN_DEF,
  parameter int T_YELLOW    = T_YELLOW_DEF,
  parameter int T_ALLRED    = T_ALLRED_DEF,
  parameter int T_MIN_GREEN = T_MIN_GREEN_DEF,
  parameter int T_WALK      = T_WALK_DEF
) (
  input logic          CLK,
  input logic          RST,
  traffic_seq_if.slave bus
);

  localparam logic [6:0] MIN_G_LAST = last_slot(7'(T_MIN_GREEN));

  state_t     state_q, state_d;
  state_t     walk_ret_q, walk_ret_d;
  logic [6:0] dur;
  logic [6:0] slot_cnt;
  logic       tick, done, green_cut, ped_pend_q;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;

  always_comb begin
    unique case (state_q)
      S_NS_G, S_EW_G: dur = 7'(T_GREEN);
      S_NS_Y, S_EW_Y: dur = 7'(T_YELLOW);
      S_WALK:         dur = 7'(T_WALK);
      default:        dur = 7'(T_ALLRED);
    endcase
  end

  slot_timer #(.SLOT_CYCLES(CLK_FREQ / 10)) u_slot_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (state_d != state_q),
    .run      (bus.enable),
    .duration (dur),
    .tick     (tick),
    .done     (done),
    .slot_cnt (slot_cnt)
  );

  // A pending pedestrian request cuts green short once the minimum green has elapsed.
  assign green_cut = tick && ped_pend_q && (slot_cnt >= MIN_G_LAST) &&
                     (state_q == S_NS_G || state_q == S_EW_G);

  always_comb begin
    state_d    = state_q;
    walk_ret_d = walk_ret_q;
    if (done || green_cut) begin
      unique case (state_q)
        S_NS_G: state_d = S_NS_Y;
        S_NS_Y: state_d = S_AR1;
        S_AR1: begin
          state_d = ped_pend_q ? S_WALK : S_EW_G;
          if (ped_pend_q) walk_ret_d = S_EW_G;
        end
        S_EW_G: state_d = S_EW_Y;
        S_EW_Y: state_d = S_AR2;
        S_AR2: begin
          state_d = ped_pend_q ? S_WALK : S_NS_G;
          if (ped_pend_q) walk_ret_d = S_NS_G;
        end
        S_WALK:  state_d = walk_ret_q;
        default: state_d = S_AR2;
      endcase
    end
  end

  // Lamps follow the state being entered, so they change on the same edge as phase.
  always_comb begin
    ns_d = LAMP_R;
    ew_d = LAMP_R;
    if (bus.enable) begin
      unique case (state_d)
        S_NS_G:  ns_d = LAMP_G;
        S_NS_Y:  ns_d = LAMP_Y;
        S_EW_G:  ew_d = LAMP_G;
        S_EW_Y:  ew_d = LAMP_Y;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_AR2;
      walk_ret_q <= S_NS_G;
      ns_q       <= LAMP_R;
      ew_q       <= LAMP_R;
    end else begin
      state_q    <= state_d;
      walk_ret_q <= walk_ret_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
    end
  end

`ifdef PED_XING_EN
  logic ped_pend_d, walk_q, walk_d;

  // A new press wins over the clear, so presses during the walk carry to the next cycle.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (bus.enable && bus.ped_req)
      ped_pend_d = 1'b1;
    else if (state_d == S_WALK && state_q != S_WALK)
      ped_pend_d = 1'b0;
    walk_d = bus.enable && (state_d == S_WALK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
    end
  end

  assign bus.walk = walk_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
  assign ped_pend_q     = 1'b0;
  assign bus.walk       = 1'b0;
`endif

  assign bus.ns_light  = ns_q;
  assign bus.ew_light  = ew_q;
  assign bus.phase     = state_q;
  assign bus.slot_left = last_slot(dur) - slot_cnt;

endmodule
